// File: rtl/control_extender_regfile.sv
// Decode-stage core: main/ALU control decoder, immediate extender and 32x32 register file.
// Optional macro REGFILE_BYPASS_EN: write-through from the writeback port to matching read ports.
module control_extender_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              we3,
  input  logic [4:0]        a3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] imm_ext,
  output logic              reg_write,
  output logic [1:0]        result_src,
  output logic              mem_write,
  output logic              jump,
  output logic              branch,
  output logic [2:0]        alu_control,
  output logic              alu_src,
  output logic [1:0]        imm_src,
  output logic              load_byte
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [DATA_W-1:0] r_regs [0:31];
  logic [6:0]        w_op;
  logic [2:0]        w_funct3;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [1:0]        w_alu_op;
  logic              w_wr_en;

  assign w_op     = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_wr_en  = we3 && (a3 != 5'd0);

  // Sign-extended immediate for the selected instruction format
  function automatic logic [31:0] extend_imm(input logic [31:0] i, input logic [1:0] sel);
    logic [31:0] v;
    case (sel)
      2'b00:   v = {{20{i[31]}}, i[31:20]};
      2'b01:   v = {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   v = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      2'b11:   v = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // Register file storage; x0 entry is never written so it stays zero after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[a3] <= wd3;
    end
  end

  // Read ports, with optional same-cycle write-through
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (w_rs1 != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (a3 == w_rs1)) begin
        rd1 = wd3;
      end else begin
        rd1 = r_regs[w_rs1];
      end
`else
      rd1 = r_regs[w_rs1];
`endif
    end else begin
      rd1 = '0;
    end
    if (w_rs2 != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (a3 == w_rs2)) begin
        rd2 = wd3;
      end else begin
        rd2 = r_regs[w_rs2];
      end
`else
      rd2 = r_regs[w_rs2];
`endif
    end else begin
      rd2 = '0;
    end
  end

  // Main decoder: unknown opcodes leave every control low
  always_comb begin
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    w_alu_op   = 2'b00;
    jump       = 1'b0;
    load_byte  = 1'b0;
    case (w_op)
      OP_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
        load_byte  = (w_funct3 == 3'b000);
      end
      OP_STORE: begin
        imm_src   = 2'b01;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_R: begin
        reg_write = 1'b1;
        w_alu_op  = 2'b10;
      end
      OP_BEQ: begin
        imm_src  = 2'b10;
        branch   = 1'b1;
        w_alu_op = 2'b01;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        w_alu_op  = 2'b10;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        imm_src    = 2'b11;
        result_src = 2'b10;
        jump       = 1'b1;
      end
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

  // ALU decoder; subtract only for R-type with funct7[5] set
  always_comb begin
    alu_control = 3'b000;
    case (w_alu_op)
      2'b00: alu_control = 3'b000;
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (w_funct3)
          3'b000: begin
            if (w_op[5] && instr[30]) begin
              alu_control = 3'b001;
            end else begin
              alu_control = 3'b000;
            end
          end
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  assign imm_ext = extend_imm(instr, imm_src);

endmodule

// File: tb/tb_control_extender_regfile.sv
// Directed self-checking bench for control_extender_regfile (both REGFILE_BYPASS_EN builds).
module tb_control_extender_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, imm_ext;
  logic        reg_write, mem_write, jump, branch, alu_src, load_byte;
  logic [1:0]  result_src, imm_src;
  logic [2:0]  alu_control;

  int n_checks = 0;
  int n_pass   = 0;

  control_extender_regfile dut (
    .clk(clk), .rst(rst), .instr(instr), .we3(we3), .a3(a3), .wd3(wd3),
    .rd1(rd1), .rd2(rd2), .imm_ext(imm_ext), .reg_write(reg_write),
    .result_src(result_src), .mem_write(mem_write), .jump(jump), .branch(branch),
    .alu_control(alu_control), .alu_src(alu_src), .imm_src(imm_src), .load_byte(load_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ctrl bundle: reg_write,result_src,mem_write,jump,branch,alu_control,alu_src,imm_src,load_byte
  task automatic chk_dec(input string tag, input logic [31:0] ins,
                         input logic [12:0] exp_ctrl, input logic [31:0] exp_imm);
    instr = ins;
    #1;
    chk({tag, "_ctrl"}, {19'd0, reg_write, result_src, mem_write, jump, branch,
                         alu_control, alu_src, imm_src, load_byte}, {19'd0, exp_ctrl});
    chk({tag, "_imm"}, imm_ext, exp_imm);
  endtask

  task automatic sel(input logic [4:0] rs1, input logic [4:0] rs2);
    instr = {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b0110011};
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we3 = 1'b1; a3 = a; wd3 = d;
    @(posedge clk);
    #1;
    we3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr = 32'd0; we3 = 1'b0; a3 = 5'd0; wd3 = 32'd0;
    #12;
    rst = 1'b0;

    // Dirty a register, then reset mid-operation
    wr(5'd3, 32'h1234_5678);
    sel(5'd3, 5'd0);
    chk("pre_rst_x3", rd1, 32'h1234_5678);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_x3", rd1, 32'h0000_0000);
    // Write on an edge during reset must be ignored
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sel(5'd9, 5'd0);
    chk("rst_write_ignored", rd1, 32'h0000_0000);

    for (int r = 1; r < 32; r++) begin
      sel(r[4:0], r[4:0]);
      chk($sformatf("rst_rd1_x%0d", r), rd1, 32'h0000_0000);
      chk($sformatf("rst_rd2_x%0d", r), rd2, 32'h0000_0000);
    end

    wr(5'd5, 32'hDEAD_BEEF);
    sel(5'd5, 5'd0);
    chk("wr_x5_rd1", rd1, 32'hDEAD_BEEF);
    chk("rs2_x0", rd2, 32'h0000_0000);
    wr(5'd31, 32'h8000_0001);
    sel(5'd0, 5'd31);
    chk("wr_x31_rd2", rd2, 32'h8000_0001);

    wr(5'd0, 32'hFFFF_FFFF);
    sel(5'd0, 5'd0);
    chk("x0_rd1", rd1, 32'h0000_0000);
    chk("x0_rd2", rd2, 32'h0000_0000);

    // Same-cycle write and read of x7
    wr(5'd7, 32'h1111_1111);
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h2222_2222;
    sel(5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_rd1", rd1, 32'h2222_2222);
    chk("same_cycle_rd2", rd2, 32'h2222_2222);
`else
    chk("same_cycle_rd1", rd1, 32'h1111_1111);
    chk("same_cycle_rd2", rd2, 32'h1111_1111);
`endif
    @(posedge clk);
    #1;
    we3 = 1'b0;
    chk("after_edge_rd1", rd1, 32'h2222_2222);
    // Write to x0 with x0 selected never bypasses
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFF_FFFF;
    sel(5'd0, 5'd7);
    chk("x0_no_bypass", rd1, 32'h0000_0000);
    we3 = 1'b0;

    chk_dec("lw",   32'hFFC4_A303, 13'b1_01_0_0_0_000_1_00_0, 32'hFFFF_FFFC);
    chk_dec("lb",   32'h0004_8303, 13'b1_01_0_0_0_000_1_00_1, 32'h0000_0000);
    chk_dec("sw",   32'h0064_A423, 13'b0_00_1_0_0_000_1_01_0, 32'h0000_0008);
    chk_dec("sub",  32'h4062_8233, 13'b1_00_0_0_0_001_0_00_0, 32'h0000_0406);
    chk_dec("and",  32'h0031_70B3, 13'b1_00_0_0_0_010_0_00_0, 32'h0000_0003);
    chk_dec("slt",  32'h0031_20B3, 13'b1_00_0_0_0_101_0_00_0, 32'h0000_0003);
    chk_dec("ori",  32'hFFF0_6293, 13'b1_00_0_0_0_011_1_00_0, 32'hFFFF_FFFF);
    chk_dec("beq",  32'hFE42_0AE3, 13'b0_00_0_0_1_001_0_10_0, 32'hFFFF_FFF4);
    chk_dec("jal",  32'h0080_00EF, 13'b1_10_0_1_0_000_0_11_0, 32'h0000_0008);
    chk_dec("addi_f7", 32'h4000_0013, 13'b1_00_0_0_0_000_1_00_0, 32'h0000_0400);
    chk_dec("lui_unk", 32'h0000_0037, 13'b0_00_0_0_0_000_0_00_0, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
